// File: rtl/qpsk_framer.sv
// qpsk_framer: frames a byte stream as preamble dibits followed by the payload
// serialized MSB-first, two bits per output beat, for the QPSK symbol mapper.
module qpsk_framer #(
  parameter int unsigned               PREAMBLE_LEN = 16,
  parameter logic [2*PREAMBLE_LEN-1:0] PREAMBLE     = 32'h1ACF_FC1D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic       out_i,
  output logic       out_q,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int unsigned PRE_W     = 2 * PREAMBLE_LEN;
  localparam int unsigned IDX_W     = $clog2(PREAMBLE_LEN + 1);
  localparam bit          ONE_DIBIT = (PREAMBLE_LEN == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    PAY  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       sr;
  logic [1:0]       cnt;
  logic             last_seen;

  logic             adv;
  logic [PRE_W-1:0] pre_shift;
  logic [1:0]       pre_dibit;

  // Output register may load when empty or when its current dibit is taken.
  assign adv = ~out_valid | out_ready;

  // Preamble dibit selected by idx, MSB-first.
  assign pre_shift = PREAMBLE << {idx, 1'b0};
  assign pre_dibit = pre_shift[PRE_W-1 -: 2];

  // A byte is taken only at a byte boundary of a frame still expecting data.
  assign s_tready = (state == PAY) && (cnt == 2'd0) && !last_seen && adv;

  // Framing state machine with registered dibit output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      sr        <= '0;
      cnt       <= '0;
      last_seen <= 1'b0;
      out_i     <= 1'b0;
      out_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (adv) begin
            if (s_tvalid) begin
              // Pending byte starts a frame but is not consumed yet.
              {out_i, out_q} <= PREAMBLE[PRE_W-1 -: 2];
              out_valid      <= 1'b1;
              idx            <= IDX_W'(1);
              if (ONE_DIBIT) begin
                state     <= PAY;
                cnt       <= 2'd0;
                last_seen <= 1'b0;
              end else begin
                state <= PRE;
              end
            end else begin
              out_valid <= 1'b0;
            end
          end
        end

        PRE: begin
          if (adv) begin
            {out_i, out_q} <= pre_dibit;
            out_valid      <= 1'b1;
            idx            <= idx + IDX_W'(1);
            if (idx == IDX_W'(PREAMBLE_LEN - 1)) begin
              state     <= PAY;
              cnt       <= 2'd0;
              last_seen <= 1'b0;
            end
          end
        end

        PAY: begin
          if (adv) begin
            if (cnt != 2'd0) begin
              {out_i, out_q} <= sr[7:6];
              out_valid      <= 1'b1;
              sr             <= {sr[5:0], 2'b00};
              cnt            <= cnt - 2'd1;
            end else if (!last_seen) begin
              if (s_tvalid) begin
                {out_i, out_q} <= s_tdata[7:6];
                out_valid      <= 1'b1;
                sr             <= {s_tdata[5:0], 2'b00};
                cnt            <= 2'd3;
                last_seen      <= s_tlast;
              end else begin
                // Underflow bubble: wait for the next byte, no preamble re-send.
                out_valid <= 1'b0;
              end
            end else begin
              out_valid <= 1'b0;
              last_seen <= 1'b0;
              idx       <= '0;
              state     <= IDLE;
            end
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_framer.sv
// tb_qpsk_framer: scoreboard bench for qpsk_framer with default preamble.
module tb_qpsk_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;
  logic       out_i;
  logic       out_q;
  logic       out_valid;
  logic       out_ready;

  qpsk_framer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } in_item_t;

  // Hand-decoded dibits of 32'h1ACF_FC1D.
  logic [1:0] pre_exp [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd3, 2'd3,
                               2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd3, 2'd1};

  in_item_t   in_q[$];
  logic [1:0] exp_q[$];
  int         len_q[$];

  int  n_tests = 0;
  int  n_fail  = 0;
  int  xfer_cnt;
  int  tready_cyc;
  int  bubbles;
  bit  bp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_pre(input int nbytes);
    for (int i = 0; i < 16; i++) exp_q.push_back(pre_exp[i]);
    len_q.push_back(16 + 4 * nbytes);
  endtask

  task automatic push_dibits(input logic [1:0] d0, input logic [1:0] d1,
                             input logic [1:0] d2, input logic [1:0] d3);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(d2);
    exp_q.push_back(d3);
  endtask

  task automatic push_in(input logic [7:0] data, input logic last, input int gap);
    in_item_t it;
    it.data = data;
    it.last = last;
    it.gap  = gap;
    in_q.push_back(it);
  endtask

  task automatic clear_counts();
    xfer_cnt   = 0;
    tready_cyc = 0;
    bubbles    = 0;
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (in_q.size() == 0 && exp_q.size() == 0 && !out_valid && !s_tvalid) begin
        done = 1'b1;
        break;
      end
    end
    check(name, int'(done), 1);
    repeat (3) @(posedge clk);
  endtask

  // Downstream ready: always 1, or 50% random when backpressure is enabled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Byte feeder: drives queued bytes, optional idle gap before each.
  initial begin
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tlast  = 1'b0;
    forever begin
      if (in_q.size() == 0) begin
        @(posedge clk);
        #1;
      end else begin
        in_item_t it;
        bit       hs_ok;
        it = in_q.pop_front();
        if (it.gap > 0) begin
          s_tvalid = 1'b0;
          repeat (it.gap) @(posedge clk);
          #1;
        end
        s_tvalid = 1'b1;
        s_tdata  = it.data;
        s_tlast  = it.last;
        hs_ok    = 1'b0;
        for (int k = 0; k < 2000; k++) begin
          @(negedge clk);
          if (s_tvalid && s_tready && rst_n) begin
            hs_ok = 1'b1;
            break;
          end
        end
        if (!hs_ok) check("byte_handshake_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (in_q.size() == 0) s_tvalid = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops on each transfer, plus stall/gap/bubble tracking.
  int         dib = 0;
  bit         waiting = 1'b0;
  int         gap = 0;
  bit         prev_stall = 1'b0;
  logic [1:0] prev_dib = 2'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      dib        = 0;
      waiting    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", int'({out_valid, out_i, out_q}), int'({1'b1, prev_dib}));
      if (out_valid && !out_ready)
        check("no_accept_stalled", int'(s_tready), 0);
      prev_stall = out_valid && !out_ready;
      prev_dib   = {out_i, out_q};
      if (s_tready) tready_cyc++;
      if (dib > 0 && !out_valid) bubbles++;
      if (waiting) begin
        if (!out_valid) gap++;
        else begin
          check("frame_gap_ge1", int'(gap >= 1), 1);
          waiting = 1'b0;
        end
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dibit_unexpected: got %b expected none (t=%0t)", {out_i, out_q}, $time);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          check("dibit", int'({out_i, out_q}), int'(e));
        end
        dib++;
        if (len_q.size() > 0 && dib == len_q[0]) begin
          void'(len_q.pop_front());
          dib     = 0;
          waiting = 1'b1;
          gap     = 0;
        end
      end
    end
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_i", int'(out_i), 0);
    check("rst_out_q", int'(out_q), 0);
    check("rst_s_tready", int'(s_tready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single byte B4 after reset; also checks start latency.
    clear_counts();
    push_pre(1);
    push_dibits(2'd2, 2'd3, 2'd1, 2'd0);
    push_in(8'hB4, 1'b1, 0);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (s_tvalid) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
    check("start_latency_valid", int'(seen && out_valid), 1);
    check("start_first_dibit", int'({out_i, out_q}), 0);
    wait_done("t1_done");
    check("t1_xfers", xfer_cnt, 20);
    check("t1_tready_cycles", tready_cyc, 1);
    check("t1_bubbles", bubbles, 0);
    check("t1_idle_valid", int'(out_valid), 0);

    // Three-byte streaming frame.
    clear_counts();
    push_pre(3);
    push_dibits(2'd0, 2'd0, 2'd0, 2'd0);
    push_dibits(2'd3, 2'd3, 2'd3, 2'd3);
    push_dibits(2'd0, 2'd1, 2'd2, 2'd3);
    push_in(8'h00, 1'b0, 0);
    push_in(8'hFF, 1'b0, 0);
    push_in(8'h1B, 1'b1, 0);
    wait_done("t2_done");
    check("t2_xfers", xfer_cnt, 28);
    check("t2_bubbles", bubbles, 0);
    check("t2_tready_cycles", tready_cyc, 3);

    // Random backpressure on a three-byte frame.
    clear_counts();
    bp_en = 1'b1;
    push_pre(3);
    push_dibits(2'd2, 2'd3, 2'd1, 2'd0);
    push_dibits(2'd0, 2'd1, 2'd2, 2'd3);
    push_dibits(2'd1, 2'd2, 2'd2, 2'd1);
    push_in(8'hB4, 1'b0, 0);
    push_in(8'h1B, 1'b0, 0);
    push_in(8'h69, 1'b1, 0);
    wait_done("t3_done");
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t3_xfers", xfer_cnt, 28);
    check("t3_bubbles", bubbles, 0);
    check("t3_tready_cycles", tready_cyc, 3);

    // Underflow: second byte arrives late, leaving five empty output cycles.
    clear_counts();
    push_pre(2);
    push_dibits(2'd1, 2'd1, 2'd2, 2'd2);
    push_dibits(2'd3, 2'd0, 2'd0, 2'd3);
    push_in(8'h5A, 1'b0, 0);
    push_in(8'hC3, 1'b1, 8);
    wait_done("t4_done");
    check("t4_xfers", xfer_cnt, 24);
    check("t4_bubbles", bubbles, 5);

    // Back-to-back single-byte frames with continuous valid.
    clear_counts();
    push_pre(1);
    push_dibits(2'd2, 2'd3, 2'd1, 2'd0);
    push_pre(1);
    push_dibits(2'd1, 2'd2, 2'd2, 2'd1);
    push_in(8'hB4, 1'b1, 0);
    push_in(8'h69, 1'b1, 0);
    wait_done("t5_done");
    check("t5_xfers", xfer_cnt, 40);
    check("t5_tready_cycles", tready_cyc, 2);

    // Reset after the second payload dibit, then resend a byte.
    clear_counts();
    push_pre(1);
    push_dibits(2'd3, 2'd2, 2'd0, 2'd1);
    push_in(8'hE1, 1'b1, 0);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (xfer_cnt == 18) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_reach_payload", int'(seen), 1);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6_rst_out_valid", int'(out_valid), 0);
    check("t6_rst_s_tready", int'(s_tready), 0);
    exp_q.delete();
    len_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_counts();
    push_pre(1);
    push_dibits(2'd0, 2'd2, 2'd3, 2'd1);
    push_in(8'h2D, 1'b1, 0);
    wait_done("t6_done");
    check("t6_xfers", xfer_cnt, 20);
    check("t6_bubbles", bubbles, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
